ysyx_25020037_icache_sa: RTL
============================

Name: ysyx_25020037_icache_sa

Overview:
- Parametrised set-associative instruction cache with multi-word lines, burst refill, `fence_i` invalidate and hit/miss performance counters.
- Sits between IFU fetch and the instruction memory/bus bridge.
- Next generation of the core-npc direct-mapped, one-word-line icache.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, fetch word width; must be 32.
- SETS, 8, number of sets; power of two, ≥2.
- WAYS, 2, associativity; 1, 2 or 4.
- LINE_WORDS, 4, words per line; power of two, ≥2.
- CNT_WIDTH, 32, width of the perf counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  fetch request; sampled only in IDLE.
- cpu_addr  in  ADDR_WIDTH  fetch byte address; captured with cpu_req.
- cpu_data  out  DATA_WIDTH  fetched instruction; valid with cpu_ready.
- cpu_ready  out  1  one-cycle response pulse.
- cpu_hit  out  1  high with cpu_ready when the response was a hit.
- fence_i  in  1  invalidate-all request (level, one-cycle pulse).
- mem_req  out  1  burst request; held high until the final beat.
- mem_addr  out  ADDR_WIDTH  line-aligned burst base address.
- mem_valid  in  1  one refill beat present on mem_data.
- mem_data  in  DATA_WIDTH  refill beat data.
- hit_cnt  out  CNT_WIDTH  lookups that hit; wraps.
- miss_cnt  out  CNT_WIDTH  lookups that missed; wraps.

Behaviour:
- Address split: offset = addr[log2(LINE_WORDS)+1:0], of which bits [1:0] are ignored. Index = next log2(SETS) bits. Tag = remainder.
- Storage: tag, valid and data arrays per way/set; data is LINE_WORDS words per line. A per-set round-robin victim pointer of log2(WAYS) bits.
- Reset (rst==0 at a clock edge):
  - State goes to IDLE. All valid bits and victim pointers are cleared.
  - Outputs: cpu_data=0, cpu_ready=0, cpu_hit=0, mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0.
  - Reset mid-refill abandons the burst. mem_valid beats arriving later are ignored.
- States: IDLE, LOOKUP, REFILL, RESP, FLUSH.
- IDLE:
  - fence_i=1 → FLUSH. fence_i has priority over a same-cycle cpu_req; that req is dropped and the IFU must re-issue it.
  - Otherwise cpu_req=1 → latch cpu_addr, go to LOOKUP.
- LOOKUP: compare the latched tag against all ways of the set.
  - Hit: cpu_data ← word, cpu_ready=1, cpu_hit=1 on the next cycle. hit_cnt++. Return to IDLE.
  - Latency: req in cycle T, response visible in T+2.
  - Miss: miss_cnt++. Choose the victim: lowest-index invalid way, else the round-robin pointer.
  - On miss, set mem_req=1 and mem_addr = {tag,index,0} registered. Go to REFILL.
- REFILL:
  - Beat counter 0..LINE_WORDS-1. Each mem_valid writes beat k into word k of the victim line, in incrementing order from word 0 (no critical-word-first).
  - Cycles without mem_valid hold all state.
  - On the last beat: mem_req←0, write tag, set valid, advance the set's pointer (mod WAYS) only if the victim was chosen by pointer. Go to RESP.
- RESP: cpu_data ← requested word from the array, cpu_ready=1, cpu_hit=0. Go to IDLE.
  - Miss latency = 3 + cycles until the last beat.
- FLUSH: clear all valid bits in one cycle; pointers are unchanged. Go to IDLE.
- fence_i outside IDLE is held pending in a 1-bit flag. It is serviced on the next IDLE entry, before any cpu_req.
- cpu_ready and cpu_hit are single-cycle pulses. cpu_data returns to 0 in every non-response cycle.
- cpu_req outside IDLE is ignored. The IFU holds it until it sees cpu_ready.
- mem_valid outside REFILL is ignored.
- Counters wrap modulo 2^CNT_WIDTH. A pending fence_i never modifies the counters.

Test Plan:
- Reset with rst=0 for 2 cycles, then read 0x8000_0000 → miss.
  - Expect mem_req=1 with mem_addr=0x8000_0000.
  - Feed 4 beats 0x11,0x22,0x33,0x44 → cpu_data=0x11, cpu_hit=0.
  - Expect miss_cnt=1.
- Read 0x8000_0008 right after → hit, cpu_ready at T+2 with cpu_data=0x33, cpu_hit=1, hit_cnt=1, no mem_req.
- Conflict, SETS=8, WAYS=2, line 16 B: fill 0x8000_0000 then 0x8000_0080 (same set, both ways); read both → both hit.
  - Read 0x8000_0100 → evicts way 0 (pointer).
  - Re-read 0x8000_0000 → miss.
- Stall mid-burst: gap mem_valid 3 cycles between beats 1 and 2 → line data is correct and mem_req stays high throughout.
- Pulse fence_i during REFILL → the refill completes and returns data, then FLUSH runs. A re-read of that address misses (miss_cnt increments).
- Assert rst=0 at beat 2 of a refill → mem_req=0 next cycle. Later beats are ignored. The subsequent read of the same address misses.

Source files
------------

// File: rtl/ysyx_25020037_icache_sa.sv
// Set-associative instruction cache between IFU fetch and the memory bridge.
// Multi-word lines, in-order burst refill, fence_i flush, hit/miss counters.
module ysyx_25020037_icache_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_ready,
  output logic                  cpu_hit,
  input  logic                  fence_i,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0] WMAX = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL, RESP, FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_q;
  logic [OFF_W-1:0] beat_q;
  logic [WAY_W-1:0] vic_q;
  logic             by_ptr_q;
  logic             fence_pend_q;

  logic [TAG_W-1:0]      tag_arr  [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_arr [WAYS][SETS][LINE_WORDS];
  logic [SETS-1:0]       valid_q  [WAYS];
  logic [WAY_W-1:0]      ptr_q    [SETS];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;

  logic unused_addr;
  assign unused_addr = ^cpu_addr[1:0];

  // tag match and lowest-index invalid way of the latched set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx_q] &&
          tag_arr[w][idx_q] == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx_q]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // next-state logic; pending fence wins over a new request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fence_i || fence_pend_q)
          state_d = FLUSH;
        else if (cpu_req)
          state_d = LOOKUP;
      end
      LOOKUP:  state_d = hit ? IDLE : REFILL;
      REFILL: begin
        if (mem_valid && beat_q == LAST)
          state_d = RESP;
      end
      RESP:    state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // control, response, counters, valid and victim pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_data     <= '0;
      cpu_ready    <= 1'b0;
      cpu_hit      <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      beat_q       <= '0;
      vic_q        <= '0;
      by_ptr_q     <= 1'b0;
      fence_pend_q <= 1'b0;
      for (int w = 0; w < WAYS; w++)
        valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++)
        ptr_q[s] <= '0;
    end else begin
      cpu_data  <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      if (fence_i && state_q != IDLE)
        fence_pend_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (fence_i || fence_pend_q) begin
            fence_pend_q <= 1'b0;
          end else if (cpu_req) begin
            tag_q <= cpu_addr[ADDR_WIDTH-1 -: TAG_W];
            idx_q <= cpu_addr[OFF_W+2 +: IDX_W];
            off_q <= cpu_addr[2 +: OFF_W];
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_data  <= data_arr[hit_way][idx_q][off_q];
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b1;
            hit_cnt   <= hit_cnt + CNT_WIDTH'(1);
          end else begin
            miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            mem_req  <= 1'b1;
            mem_addr <= {tag_q, idx_q, {(OFF_W+2){1'b0}}};
            vic_q    <= inv_found ? inv_way : ptr_q[idx_q];
            by_ptr_q <= !inv_found;
            beat_q   <= '0;
          end
        end
        REFILL: begin
          if (mem_valid) begin
            beat_q <= beat_q + OFF_W'(1);
            if (beat_q == LAST) begin
              mem_req <= 1'b0;
              valid_q[vic_q][idx_q] <= 1'b1;
              if (by_ptr_q)
                ptr_q[idx_q] <= (ptr_q[idx_q] == WMAX) ?
                  '0 : ptr_q[idx_q] + WAY_W'(1);
            end
          end
        end
        RESP: begin
          cpu_data  <= data_arr[vic_q][idx_q][off_q];
          cpu_ready <= 1'b1;
        end
        FLUSH: begin
          for (int w = 0; w < WAYS; w++)
            valid_q[w] <= '0;
        end
        default: ;
      endcase
    end
  end

  // line storage: beats land in order, tag written with the last beat
  always_ff @(posedge clk) begin
    if (rst && state_q == REFILL && mem_valid) begin
      data_arr[vic_q][idx_q][beat_q] <= mem_data;
      if (beat_q == LAST)
        tag_arr[vic_q][idx_q] <= tag_q;
    end
  end

endmodule
